// File: rtl/sfp_pkt_pkg.sv
// Shared definitions for the SFP packet paths: word geometry, length width,
// receive FSM states and the byte-to-lane mapping used by both directions.
package sfp_pkt_pkg;

  localparam int WORD_BYTES = 32;
  localparam int LEN_W      = 11;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RECV    = 3'd1,
    WR_DATA = 3'd2,
    FLUSH   = 3'd3,
    WR_HDR  = 3'd4,
    DONE    = 3'd5
  } rx_state_t;

  // LSB position of byte k inside a 256-bit word: 32-bit groups ascend,
  // bytes inside a group are big-endian (byte 0 sits in bits [31:24]).
  function automatic logic [7:0] lane_lsb(input logic [4:0] k);
    return {k[4:2], 5'd0} + 8'd24 - {3'd0, k[1:0], 3'd0};
  endfunction

endpackage

// File: rtl/rx_word_packer.sv
// 8-to-256 byte-lane assembler. A clear and a write in the same cycle yield a
// word holding only the new byte, which lets a frame restart without a bubble.
module rx_word_packer
  import sfp_pkt_pkg::*;
(
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         wr_en_i,
  input  logic [4:0]   idx_i,
  input  logic [7:0]   byte_i,
  output logic [255:0] word_o
);

  logic [255:0] word_q, word_d;

  // Next word: optional clear, then drop the byte into its lane.
  always_comb begin
    word_d = clr_i ? '0 : word_q;
    if (wr_en_i) word_d[lane_lsb(idx_i) +: 8] = byte_i;
  end

  // Assembly register.
  always_ff @(posedge clk_i) begin
    if (rst_i) word_q <= '0;
    else       word_q <= word_d;
  end

  assign word_o = word_q;

endmodule

// File: rtl/receive_packet_ddr.sv
// Receives TSE RX frames, packs them into 256-bit words written to DDR at
// base+1.., then writes a header word at base holding the stored byte count.
// Build option RX_ERR_DROP_EN: a frame flagged with ff_rx_err at EOP gets no
// header and no pkt_done; otherwise the error is reported in header bit 15.
// Handshake: a write is offered while wr_rq is high with wr_adr/wr_data held
// stable; it completes on the cycle action_done is high, and wr_rq drops or
// moves to the next write on the following cycle. action_done with wr_rq low
// has no effect.
module receive_packet_ddr
  import sfp_pkt_pkg::*;
#(
  parameter int MAX_BYTES = 256,
  parameter int ADDR_W    = 25
) (
  input  logic              clk_original,
  input  logic              rst,
  input  logic [ADDR_W-1:0] start_ram_addr,
  input  logic [7:0]        ff_rx_data,
  input  logic              ff_rx_sop,
  input  logic              ff_rx_eop,
  input  logic              ff_rx_dval,
  input  logic              ff_rx_err,
  output logic              ff_rx_rdy,
  output logic              wr_rq,
  output logic [ADDR_W-1:0] wr_adr,
  output logic [255:0]      wr_data,
  output logic [31:0]       byte_enable,
  input  logic              action_done,
  output logic              pkt_done,
  output logic [10:0]       pkt_size,
  output logic              pkt_overflow,
  output logic [2:0]        dbg_state
);

  localparam logic [15:0] MAX_CNT = 16'(MAX_BYTES);

  rx_state_t         state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] word_idx_q, word_idx_d;
  logic [15:0]       byte_cnt_q, byte_cnt_d;   // saturating, counts unstored bytes too
  logic              pend_q, pend_d;           // assembly word holds unwritten bytes
  logic              err_q, err_d;
  logic              ovf_q, ovf_d;

  logic              pk_clr, pk_wr;
  logic [4:0]        pk_idx;
  logic [255:0]      word;
  logic [255:0]      hdr_word;
  logic [LEN_W-1:0]  stored_len;
  logic              accept, data_rq, hdr_rq;
  rx_state_t         after_flush;

  rx_word_packer u_packer (
    .clk_i   (clk_original),
    .rst_i   (rst),
    .clr_i   (pk_clr),
    .wr_en_i (pk_wr),
    .idx_i   (pk_idx),
    .byte_i  (ff_rx_data),
    .word_o  (word)
  );

  assign stored_len = (byte_cnt_q >= MAX_CNT) ? LEN_W'(MAX_BYTES) : byte_cnt_q[LEN_W-1:0];
  assign ff_rx_rdy  = ((state_q == IDLE) || (state_q == RECV)) && !rst;
  assign accept     = ff_rx_dval && ff_rx_rdy;
  assign data_rq    = (state_q == WR_DATA) || ((state_q == FLUSH) && pend_q);
  assign hdr_rq     = (state_q == WR_HDR);

`ifdef RX_ERR_DROP_EN
  assign after_flush = err_q ? IDLE : WR_HDR;
`else
  assign after_flush = WR_HDR;
`endif

  // Header word: stored length in the low bits, error flag in bit 15.
  always_comb begin
    hdr_word = '0;
    hdr_word[LEN_W-1:0] = stored_len;
`ifdef RX_ERR_DROP_EN
    hdr_word[15] = 1'b0;  // errored frames never reach WR_HDR
`else
    hdr_word[15] = err_q;
`endif
  end

  // Next-state and datapath control.
  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    word_idx_d = word_idx_q;
    byte_cnt_d = byte_cnt_q;
    pend_d     = pend_q;
    err_d      = err_q;
    ovf_d      = ovf_q;
    pk_clr     = 1'b0;
    pk_wr      = 1'b0;
    pk_idx     = byte_cnt_q[4:0];
    if (accept && ff_rx_sop) begin
      // SOP in IDLE or RECV (re)starts a frame at byte 0.
      base_d     = start_ram_addr;
      word_idx_d = '0;
      byte_cnt_d = 16'd1;
      pend_d     = 1'b1;
      ovf_d      = 1'b0;
      err_d      = ff_rx_eop && ff_rx_err;
      pk_clr     = 1'b1;
      pk_wr      = 1'b1;
      pk_idx     = 5'd0;
      state_d    = ff_rx_eop ? FLUSH : RECV;
    end else begin
      case (state_q)
        RECV: begin
          if (accept) begin
            if (byte_cnt_q < MAX_CNT) begin
              pk_wr  = 1'b1;
              pend_d = 1'b1;
            end else begin
              ovf_d = 1'b1;
            end
            if (byte_cnt_q != 16'hFFFF) byte_cnt_d = byte_cnt_q + 16'd1;
            if (ff_rx_eop) begin
              err_d   = ff_rx_err;
              state_d = FLUSH;
            end else if ((byte_cnt_q < MAX_CNT) && (byte_cnt_q[4:0] == 5'd31)) begin
              state_d = WR_DATA;
            end
          end
        end
        WR_DATA: begin
          if (action_done) begin
            pk_clr     = 1'b1;
            pend_d     = 1'b0;
            word_idx_d = word_idx_q + ADDR_W'(1);
            state_d    = RECV;
          end
        end
        FLUSH: begin
          if (!pend_q) begin
            state_d = after_flush;
          end else if (action_done) begin
            pk_clr     = 1'b1;
            pend_d     = 1'b0;
            word_idx_d = word_idx_q + ADDR_W'(1);
            state_d    = after_flush;
          end
        end
        WR_HDR: if (action_done) state_d = DONE;
        DONE:   state_d = IDLE;
        default: ;
      endcase
    end
  end

  // State and frame registers.
  always_ff @(posedge clk_original) begin
    if (rst) begin
      state_q    <= IDLE;
      base_q     <= '0;
      word_idx_q <= '0;
      byte_cnt_q <= '0;
      pend_q     <= 1'b0;
      err_q      <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      word_idx_q <= word_idx_d;
      byte_cnt_q <= byte_cnt_d;
      pend_q     <= pend_d;
      err_q      <= err_d;
      ovf_q      <= ovf_d;
    end
  end

  assign wr_rq        = data_rq || hdr_rq;
  assign wr_adr       = data_rq ? (base_q + ADDR_W'(1) + word_idx_q) : (hdr_rq ? base_q : '0);
  assign wr_data      = data_rq ? word : (hdr_rq ? hdr_word : '0);
  assign byte_enable  = '1;
  assign pkt_done     = (state_q == DONE);
  assign pkt_size     = pkt_done ? stored_len : '0;
  assign pkt_overflow = ovf_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_receive_packet_ddr.sv
// Bench for receive_packet_ddr: directed frames, DDR responder with
// programmable latency, scoreboard of expected writes and packet sizes.
module tb_receive_packet_ddr;

  localparam int ADDR_W    = 25;
  localparam int MAX_BYTES = 256;

  logic              clk = 1'b0;
  logic              rst;
  logic [ADDR_W-1:0] start_ram_addr;
  logic [7:0]        ff_rx_data;
  logic              ff_rx_sop, ff_rx_eop, ff_rx_dval, ff_rx_err;
  logic              ff_rx_rdy;
  logic              wr_rq;
  logic [ADDR_W-1:0] wr_adr;
  logic [255:0]      wr_data;
  logic [31:0]       byte_enable;
  logic              action_done;
  logic              pkt_done;
  logic [10:0]       pkt_size;
  logic              pkt_overflow;
  logic [2:0]        dbg_state;

  logic [ADDR_W+255:0] exp_q[$];
  logic [10:0]         exp_size_q[$];
  logic [7:0]          frame_b[0:511];

  int   checks = 0;
  int   failures = 0;
  int   resp_delay = 3;
  int   wait_cnt = 0;
  logic stray_pulse = 1'b0;

  receive_packet_ddr #(.MAX_BYTES(MAX_BYTES), .ADDR_W(ADDR_W)) dut (
    .clk_original   (clk),
    .rst            (rst),
    .start_ram_addr (start_ram_addr),
    .ff_rx_data     (ff_rx_data),
    .ff_rx_sop      (ff_rx_sop),
    .ff_rx_eop      (ff_rx_eop),
    .ff_rx_dval     (ff_rx_dval),
    .ff_rx_err      (ff_rx_err),
    .ff_rx_rdy      (ff_rx_rdy),
    .wr_rq          (wr_rq),
    .wr_adr         (wr_adr),
    .wr_data        (wr_data),
    .byte_enable    (byte_enable),
    .action_done    (action_done),
    .pkt_done       (pkt_done),
    .pkt_size       (pkt_size),
    .pkt_overflow   (pkt_overflow),
    .dbg_state      (dbg_state)
  );

  // Clock.
  always #5 clk = ~clk;

  // DDR responder: completes each request resp_delay cycles after it appears.
  initial begin
    action_done = 1'b0;
    forever begin
      @(posedge clk); #1;
      action_done = 1'b0;
      if (rst) begin
        wait_cnt = 0;
      end else if (wr_rq) begin
        if (wait_cnt >= resp_delay) begin
          action_done = 1'b1;
          wait_cnt = 0;
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
        if (stray_pulse) begin
          action_done = 1'b1;
          stray_pulse = 1'b0;
        end
      end
    end
  end

  // Monitor: compares completed writes and pkt_done against the scoreboard.
  initial begin
    logic                prev_rq, prev_done;
    logic [ADDR_W-1:0]   prev_adr;
    logic [255:0]        prev_data;
    logic [ADDR_W+255:0] e;
    logic [10:0]         es;
    prev_rq = 1'b0; prev_done = 1'b0; prev_adr = '0; prev_data = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (wr_rq) begin
          checks++;
          if (ff_rx_rdy !== 1'b0) begin
            failures++;
            $display("FAIL rdy_during_write got=%b want=0", ff_rx_rdy);
          end
          if (prev_rq && !prev_done) begin
            checks++;
            if (wr_adr !== prev_adr || wr_data !== prev_data) begin
              failures++;
              $display("FAIL request_stable adr=%h was=%h", wr_adr, prev_adr);
            end
          end
          if (action_done) begin
            checks++;
            if (exp_q.size() == 0) begin
              failures++;
              $display("FAIL unexpected_write adr=%h data=%h", wr_adr, wr_data);
            end else begin
              e = exp_q.pop_front();
              if ({wr_adr, wr_data} !== e) begin
                failures++;
                $display("FAIL ddr_write got adr=%h data=%h want adr=%h data=%h",
                         wr_adr, wr_data, e[ADDR_W+255:256], e[255:0]);
              end
            end
          end
        end
        if (pkt_done) begin
          checks++;
          if (exp_size_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_pkt_done size=%0d", pkt_size);
          end else begin
            es = exp_size_q.pop_front();
            if (pkt_size !== es) begin
              failures++;
              $display("FAIL pkt_size got=%0d want=%0d", pkt_size, es);
            end
          end
        end
      end
      prev_rq = wr_rq && !rst; prev_done = action_done; prev_adr = wr_adr; prev_data = wr_data;
    end
  end

  task automatic check(input string name, input logic [255:0] got, input logic [255:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic fill(input int len, input logic [7:0] seed);
    for (int i = 0; i < len; i++) frame_b[i] = 8'(seed + i);
  endtask

  // Reference model: expected DDR writes and packet size for one frame.
  task automatic expect_frame(input int len, input logic [ADDR_W-1:0] start, input logic err);
    int                stored, nwords, pos, idx;
    logic [255:0]      d;
    logic [ADDR_W-1:0] a;
    stored = (len > MAX_BYTES) ? MAX_BYTES : len;
    nwords = (stored + 31) / 32;
    for (int w = 0; w < nwords; w++) begin
      d = '0;
      for (int j = 0; j < 32; j++) begin
        idx = w * 32 + j;
        pos = (j / 4) * 32 + 31 - 8 * (j % 4);
        if (idx < stored) d[pos -: 8] = frame_b[idx];
      end
      a = start + ADDR_W'(1) + ADDR_W'(w);
      exp_q.push_back({a, d});
    end
`ifdef RX_ERR_DROP_EN
    if (err) return;
`endif
    d = '0;
    d[10:0] = 11'(stored);
`ifndef RX_ERR_DROP_EN
    d[15] = err;
`endif
    exp_q.push_back({start, d});
    exp_size_q.push_back(11'(stored));
  endtask

  // Driver: one byte per accepted cycle; start address is scrambled after SOP.
  task automatic send_frame(input int len, input logic [ADDR_W-1:0] start,
                            input logic err, input logic with_eop);
    int tmo;
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      start_ram_addr = (i == 0) ? start : ADDR_W'($urandom);
      ff_rx_data = frame_b[i];
      ff_rx_sop  = (i == 0);
      ff_rx_eop  = with_eop && (i == len - 1);
      ff_rx_err  = ff_rx_eop ? err : 1'($urandom_range(0, 1));
      ff_rx_dval = 1'b1;
      tmo = 0;
      while (!ff_rx_rdy && tmo < 500) begin
        @(negedge clk);
        tmo++;
      end
      if (tmo >= 500) begin
        checks++; failures++;
        $display("FAIL rx_rdy_timeout byte=%0d", i);
      end
    end
    @(negedge clk);
    ff_rx_dval = 1'b0; ff_rx_sop = 1'b0; ff_rx_eop = 1'b0; ff_rx_err = 1'b0;
  endtask

  task automatic wait_idle();
    int tmo = 0;
    while ((exp_q.size() != 0 || exp_size_q.size() != 0 || dbg_state != 3'd0) && tmo < 3000) begin
      @(negedge clk);
      tmo++;
    end
    if (tmo >= 3000) begin
      checks++; failures++;
      $display("FAIL completion_timeout pending_writes=%0d pending_sizes=%0d", exp_q.size(), exp_size_q.size());
      exp_q.delete(); exp_size_q.delete();
    end
    repeat (10) @(negedge clk);
  endtask

  // Stimulus.
  initial begin
    rst = 1'b1; start_ram_addr = '0; ff_rx_data = '0;
    ff_rx_sop = 1'b0; ff_rx_eop = 1'b0; ff_rx_dval = 1'b0; ff_rx_err = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_rdy",      256'(ff_rx_rdy),    256'd0);
    check("rst_wr_rq",    256'(wr_rq),        256'd0);
    check("rst_wr_adr",   256'(wr_adr),       256'd0);
    check("rst_wr_data",  wr_data,            256'd0);
    check("rst_pkt_done", 256'(pkt_done),     256'd0);
    check("rst_pkt_size", 256'(pkt_size),     256'd0);
    check("rst_overflow", 256'(pkt_overflow), 256'd0);
    check("rst_state",    256'(dbg_state),    256'd0);
    check("byte_enable",  256'(byte_enable),  256'hFFFF_FFFF);
    rst = 1'b0;
    @(negedge clk);

    // 64-byte frame 0x00..0x3F at 0x100.
    resp_delay = 3;
    fill(64, 8'h00);
    expect_frame(64, 25'h100, 1'b0);
    send_frame(64, 25'h100, 1'b0, 1'b1);
    wait_idle();

    // Bytes without SOP in IDLE are dropped, then a 1-byte frame.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      ff_rx_data = 8'h5A; ff_rx_dval = 1'b1;
    end
    @(negedge clk);
    ff_rx_dval = 1'b0;
    check("no_sop_dropped", 256'(dbg_state), 256'd0);
    fill(1, 8'hA5);
    expect_frame(1, 25'h100, 1'b0);
    send_frame(1, 25'h100, 1'b0, 1'b1);
    wait_idle();

    // Stray action_done while idle must be ignored.
    stray_pulse = 1'b1;
    repeat (3) @(negedge clk);
    check("stray_done_state", 256'(dbg_state), 256'd0);
    check("stray_done_rq",    256'(wr_rq),     256'd0);

    // 33-byte frame with slow completion.
    resp_delay = 10;
    fill(33, 8'h40);
    expect_frame(33, 25'h200, 1'b0);
    send_frame(33, 25'h200, 1'b0, 1'b1);
    wait_idle();

    // 300-byte frame overflows MAX_BYTES.
    resp_delay = 2;
    fill(300, 8'h10);
    expect_frame(300, 25'h1000, 1'b0);
    send_frame(300, 25'h1000, 1'b0, 1'b1);
    wait_idle();
    check("overflow_set", 256'(pkt_overflow), 256'd1);

    // 40-byte frame with error at EOP; SOP clears overflow.
    fill(40, 8'h80);
    expect_frame(40, 25'h500, 1'b1);
    send_frame(40, 25'h500, 1'b1, 1'b1);
    wait_idle();
    check("overflow_cleared", 256'(pkt_overflow), 256'd0);

    // Address wrap: 5-byte frame at the top of the address space.
    resp_delay = 0;
    fill(5, 8'hC0);
    expect_frame(5, 25'h1FF_FFFF, 1'b0);
    send_frame(5, 25'h1FF_FFFF, 1'b0, 1'b1);
    wait_idle();

    // Reset while a data write is pending.
    resp_delay = 60;
    fill(32, 8'h20);
    send_frame(32, 25'h300, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    check("pre_rst_state", 256'(dbg_state), 256'd2);
    check("pre_rst_rq",    256'(wr_rq),     256'd1);
    check("pre_rst_adr",   256'(wr_adr),    256'h301);
    rst = 1'b1;
    @(negedge clk);
    check("abort_rq",    256'(wr_rq),     256'd0);
    check("abort_state", 256'(dbg_state), 256'd0);
    rst = 1'b0;
    @(negedge clk);
    resp_delay = 2;
    fill(32, 8'h60);
    expect_frame(32, 25'h400, 1'b0);
    send_frame(32, 25'h400, 1'b0, 1'b1);
    wait_idle();

    check("sb_writes_empty", 256'(exp_q.size()),      256'd0);
    check("sb_sizes_empty",  256'(exp_size_q.size()), 256'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/receive_packet_ddr.md
Name: receive_packet_ddr

Overview:
- Receive-side counterpart of the TSE-to-DDR transmit path.
- Accepts Ethernet frames from the TSE Avalon-ST RX FIFO interface (ff_rx_*) and packs bytes into 256-bit words.
- Writes the words to DDR through the avalon_mm_ddr request interface (wr_rq/action_done), then writes a header word at start_ram_addr holding the byte count.
- The DDR layout is exactly the one the transmit path reads back.

Parameters:
- MAX_BYTES, 256: maximum stored packet length in bytes; must be a multiple of 32.
- ADDR_W, 25: DDR word-address width.

Ports:
- clk_original  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start_ram_addr  in  ADDR_W  header word address, sampled at SOP
- ff_rx_data  in  8  RX byte
- ff_rx_sop  in  1  first byte of frame
- ff_rx_eop  in  1  last byte of frame
- ff_rx_dval  in  1  byte valid
- ff_rx_err  in  1  frame error, qualified at EOP
- ff_rx_rdy  out  1  block can accept a byte
- wr_rq  out  1  DDR write request
- wr_adr  out  ADDR_W  DDR word address
- wr_data  out  256  DDR write data
- byte_enable  out  32  always all ones
- action_done  in  1  one-cycle pulse: the current write has completed
- pkt_done  out  1  one-cycle pulse: header written
- pkt_size  out  11  byte count of the last packet, valid while pkt_done is high
- pkt_overflow  out  1  sticky; set when a frame exceeds MAX_BYTES; cleared at the next SOP

Behaviour:
- Reset (synchronous, rst high at the clock edge): state=IDLE. Reset values: ff_rx_rdy=0, wr_rq=0, wr_adr=0, wr_data=0, pkt_done=0, pkt_size=0, pkt_overflow=0, byte and word counters 0.
- A byte is accepted when ff_rx_dval & ff_rx_rdy.
- States:
  - IDLE: ff_rx_rdy=1; bytes without SOP are discarded. On an accepted SOP byte: latch base=start_ram_addr, store the byte at index 0, byte_cnt=1, go to RECV. If that byte also has EOP, go to FLUSH.
  - RECV: ff_rx_rdy=1.
    - Accepted byte k (0-based, k = byte_cnt mod 32) goes to lane bits [(k/4)*32 + 31 - 8*(k%4) -: 8]; then byte_cnt++.
    - When the 32nd byte of a word is accepted without EOP: go to WR_DATA.
    - When the EOP byte is accepted: go to FLUSH.
    - Bytes beyond MAX_BYTES: counted, not stored; set pkt_overflow.
    - SOP seen in RECV restarts the frame; byte_cnt counts from 1.
  - WR_DATA: ff_rx_rdy=0; wr_rq=1, wr_adr=base+1+word_idx, wr_data=assembled word. On action_done: wr_rq=0 the next cycle, word_idx++, clear the assembly register, return to RECV.
  - FLUSH: a partial word (byte_cnt mod 32 ≠ 0, stored bytes only) is written like WR_DATA, with unused lanes zero. Then go to WR_HDR. If there is no partial word, go straight to WR_HDR.
  - WR_HDR: wr_rq=1, wr_adr=base, wr_data = {245'd0, stored_len[10:0]}. On action_done: go to DONE.
  - DONE: one cycle; pkt_done=1, pkt_size=stored_len; go to IDLE.
- stored_len = min(byte_cnt, MAX_BYTES).
- wr_adr, wr_data and wr_rq are held stable from request until action_done is seen.
- action_done received while wr_rq=0 is ignored.
- Address arithmetic is modulo 2^ADDR_W (wraps).
- Latency: header request is issued at most 2 cycles after the EOP byte when no partial word is pending.
- Reset during any state aborts immediately. A pending wr_rq drops; no header is written.

Optional Feature:
- Macro: RX_ERR_DROP_EN.
- Defined: if ff_rx_err is high on the EOP byte, skip WR_HDR and go to IDLE. No pkt_done; the data words written so far are orphaned, and the header at base is untouched.
- Undefined: the header is written normally, with bit 15 of wr_data = ff_rx_err.

Decomposition:
- Package sfp_pkt_pkg:
  - WORD_BYTES=32, LEN_W=11.
  - State enum rx_state_t {IDLE, RECV, WR_DATA, FLUSH, WR_HDR, DONE}.
  - Lane-index function shared with the transmit path.
- Natural sub-module: rx_word_packer, an 8-to-256 byte-lane assembler with clear and a byte index.

Test Plan:
- 64-byte frame with bytes 0x00..0x3F, start=0x100, action_done 3 cycles after each request: writes 0x101 and 0x102, then header 0x100 = 64. Word 0x101 bits [255:248]=0x1C. pkt_done pulses with pkt_size=64.
- 1-byte frame (SOP+EOP, 0xA5): write 0x101 with bits [31:24]=0xA5, all other bits 0; header=1.
- 33-byte frame, action_done delayed 10 cycles: ff_rx_rdy low throughout WR_DATA; wr_adr/wr_data stable; header=33.
- 300-byte frame, MAX_BYTES=256: 8 data writes only; header=256; pkt_overflow=1 until the next SOP.
- ff_rx_err on the EOP byte of a 40-byte frame:
  - Macro defined: no header write, no pkt_done.
  - Macro undefined: header = 0x8028.
- rst asserted during WR_DATA: next cycle wr_rq=0, state IDLE; a subsequent 32-byte frame completes correctly.
